// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage pipeline register with valid/ready flow control.
//
// Each stage holds one word plus a valid bit. A stage accepts from upstream
// whenever it is empty or the stage after it is accepting, so bubbles
// compress and a full, stalled pipe holds exactly DEPTH words.
//
// Handshake: a word moves across an interface on a rising edge where
// valid and ready are both high. in_ready depends combinationally on
// out_ready and the stage valids; out_valid/data_out come straight from the
// final stage register.
//
// flush clears every stage valid at the next edge (data left untouched) and
// masks in_ready so nothing is captured during a flush cycle.
//
// Optional build macro ELASTIC_PIPE_REG_LEVEL_EN adds a `level` output: the
// registered count of valid stages.
module elastic_pipe_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
`ifdef ELASTIC_PIPE_REG_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_up_valid;
  logic [WIDTH-1:0] w_up_data [DEPTH];

  // Stage readiness: rdy_k = !valid_k || rdy_{k+1}, rdy_DEPTH = out_ready.
  // Built as a suffix OR from the output end so no signal feeds itself.
  always_comb begin : p_rdy
    logic v_acc;
    v_acc = out_ready;
    w_rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      v_acc    = v_acc | ~r_valid[k];
      w_rdy[k] = v_acc;
    end
  end

  // Upstream source for each stage: input port for stage 0, previous stage otherwise.
  always_comb begin
    w_up_valid[0] = in_valid;
    w_up_data[0]  = data_in;
    for (int k = 1; k < DEPTH; k++) begin
      w_up_valid[k] = r_valid[k-1];
      w_up_data[k]  = r_data[k-1];
    end
  end

  // Stage registers: flush wins over load; data only loads behind a valid word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          r_valid[k] <= w_up_valid[k];
          if (w_up_valid[k]) begin
            r_data[k] <= w_up_data[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = r_valid[DEPTH-1];
  assign data_out  = r_data[DEPTH-1];

`ifdef ELASTIC_PIPE_REG_LEVEL_EN
  localparam int LW = $clog2(DEPTH + 1);

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [LW-1:0] r_level;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Occupancy counter tracking the number of set stage valids.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
    end else if (flush) begin
      r_level <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_level <= r_level + LW'(1);
    end else if (w_out_xfer && !w_in_xfer) begin
      r_level <= r_level - LW'(1);
    end
  end

  assign level = r_level;
`endif

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised multi-stage pipeline register with valid/ready flow control.
- Generalises the single-stage parallel register: configurable data width and stage count, per-stage backpressure, and a synchronous flush.
- Sits between UDP/TCP datapath blocks (checksum, header build, payload mux) to break timing paths without losing or duplicating words.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 2, number of register stages (>=1). Unstalled latency equals DEPTH cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream word present on data_in.
- in_ready  output  1  block accepts data_in this cycle.
- data_in  input  WIDTH  upstream data.
- out_valid  output  1  data_out holds a valid word.
- out_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  WIDTH  word from final stage.

Behaviour:
- Structure: stage k (0..DEPTH-1) holds data_k and valid_k. Stage 0 is fed from data_in. Stage DEPTH-1 drives data_out and out_valid.
- Stage readiness: rdy_k = !valid_k || rdy_{k+1}, with rdy_DEPTH = out_ready. This is a combinational chain; in_ready = rdy_0.
- Stage k loads when rdy_k is high:
  - data_k <= upstream data and valid_k <= upstream valid.
  - Upstream for stage 0 is data_in/in_valid; for stage k>0 it is stage k-1.
  - A stage whose rdy is low holds its contents.
- Data registers load only when the upstream valid is high, so bubbles do not toggle data.
- Transfers: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
- Ordering: words leave in arrival order. There is no loss or duplication under any valid/ready pattern.
- Throughput: one word per cycle while out_ready is held high.
- Latency: with no stalls, a word accepted at edge N appears on data_out after edge N+DEPTH-1, i.e. DEPTH register delays.
- Bubbles: an empty stage ahead of a stalled stage still accepts, so bubbles compress. When full and stalled, the block holds exactly DEPTH words.
- Full, stalled: out_ready=0 with all valids set drives in_ready low in the same cycle. data_out and out_valid stay stable until an output transfer.
- Empty: out_valid=0 and data_out holds its last value; the value is don't-care to consumers.
- Reset (reset=0, asynchronous): all valid_k=0 and all data_k=0, so out_valid=0 and data_out=0. in_ready reads 1 during and after reset.
- Reset mid-operation: all in-flight words are discarded immediately, with no partial output.
- Flush (sync, high for one or more cycles):
  - At the next edge, all valid_k are cleared; data is unchanged.
  - A word presented on data_in in the same cycle is NOT captured, and in_ready is forced to 0 while flush=1.
  - Flush has priority over simultaneous load and advance.
- Simultaneous in/out transfer when full: allowed. Occupancy is unchanged and the pipeline shifts by one.

Optional Feature:
- Macro ELASTIC_PIPE_REG_LEVEL_EN.
- Defined:
  - Adds output port level [$clog2(DEPTH+1)-1:0], the registered count of valid stages. It is always equal to the number of valid_k set.
  - level increments on an input transfer alone, decrements on an output transfer alone, and is unchanged when both or neither occur.
  - level resets to 0 on reset and clears to 0 on flush.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset, then DEPTH=2, WIDTH=32, out_ready=1; drive 1,2,3,4 on consecutive cycles -> data_out shows 1,2,3,4 on consecutive cycles starting 2 edges after first accept; in_ready stays 1.
2. out_ready=0, push 0xA,0xB -> after 2 accepts in_ready=0; data_out=0xA held. Then out_ready=1 for 2 cycles -> 0xA then 0xB out, no duplicates.
3. Random in_valid/out_ready (~50% each), 1000 words with incrementing values -> scoreboard sees exact incrementing sequence, no loss or duplication.
4. Pipeline holding 2 words, assert flush for 1 cycle with in_valid=1, data_in=0x55 -> next cycle out_valid=0, 0x55 not emitted, in_ready=0 during flush.
5. Mid-stream, drop reset to 0 between clock edges -> out_valid and data_out go to 0 immediately (asynchronous); after release the first new word passes with normal latency.
6. With ELASTIC_PIPE_REG_LEVEL_EN, DEPTH=4:
   - Push 3 words with out_ready=0 -> level=3.
   - Simultaneous in/out transfer -> level stays 3.
   - Flush -> level=0.
